// File: rtl/top_uart.sv
// UART echo: an 8N1 receiver fills a one-entry holding register that an 8N1 transmitter drains.
// The newest valid byte overwrites an unsent one; framing errors and start-bit glitches are dropped.
module top_uart #(
    parameter int CLK_FREQ     = 50_000_000,
    parameter int BAUD_RATE    = 115200,
    parameter int CLKS_PER_BIT = CLK_FREQ / BAUD_RATE
) (
    input  logic sys_clk,
    input  logic sys_rst,
    input  logic rx_data,
    output logic tx_data
);
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] CNT_ZERO  = {CW{1'b0}};
    localparam logic [CW-1:0] CNT_ONE   = {{(CW-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } state_t;

    logic          sync1_r;
    logic          sync2_r;
    state_t        rx_state_r;
    logic [CW-1:0] rx_cnt_r;
    logic [2:0]    rx_bit_r;
    logic [7:0]    rx_shift_r;
    logic [7:0]    hold_r;
    logic          pending_r;
    state_t        tx_state_r;
    logic [CW-1:0] tx_cnt_r;
    logic [2:0]    tx_bit_r;
    logic [7:0]    tx_shift_r;
    logic          tx_r;
    logic          tx_take_s;

    // Two-flop synchronizer for the asynchronous serial input, idling high.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            sync1_r <= 1'b1;
            sync2_r <= 1'b1;
        end else begin
            sync1_r <= rx_data;
            sync2_r <= sync1_r;
        end
    end

    // Transmitter claims the held byte whenever it is idle.
    always_comb begin
        tx_take_s = (tx_state_r == ST_IDLE) && pending_r;
    end

    // Receive FSM plus holding register; a new valid byte wins over a same-cycle claim.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            rx_state_r <= ST_IDLE;
            rx_cnt_r   <= CNT_ZERO;
            rx_bit_r   <= 3'd0;
            rx_shift_r <= 8'h00;
            hold_r     <= 8'h00;
            pending_r  <= 1'b0;
        end else begin
            if (tx_take_s) begin
                pending_r <= 1'b0;
            end
            case (rx_state_r)
                ST_IDLE: begin
                    rx_cnt_r <= CNT_ZERO;
                    rx_bit_r <= 3'd0;
                    if (!sync2_r) rx_state_r <= ST_START;
                    else          rx_state_r <= ST_IDLE;
                end
                ST_START: begin
                    if (rx_cnt_r == HALF_LAST) begin
                        rx_cnt_r   <= CNT_ZERO;
                        rx_state_r <= sync2_r ? ST_IDLE : ST_DATA;
                    end else begin
                        rx_cnt_r <= rx_cnt_r + CNT_ONE;
                    end
                end
                ST_DATA: begin
                    if (rx_cnt_r == BIT_LAST) begin
                        rx_cnt_r   <= CNT_ZERO;
                        rx_shift_r <= {sync2_r, rx_shift_r[7:1]};
                        if (rx_bit_r == 3'd7) rx_state_r <= ST_STOP;
                        else                  rx_bit_r   <= rx_bit_r + 3'd1;
                    end else begin
                        rx_cnt_r <= rx_cnt_r + CNT_ONE;
                    end
                end
                ST_STOP: begin
                    if (rx_cnt_r == BIT_LAST) begin
                        rx_cnt_r   <= CNT_ZERO;
                        rx_state_r <= ST_IDLE;
                        if (sync2_r) begin
                            hold_r    <= rx_shift_r;
                            pending_r <= 1'b1;
                        end
                    end else begin
                        rx_cnt_r <= rx_cnt_r + CNT_ONE;
                    end
                end
                default: rx_state_r <= ST_IDLE;
            endcase
        end
    end

    // Transmit FSM; the line is driven straight from tx_r so it never glitches.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            tx_state_r <= ST_IDLE;
            tx_cnt_r   <= CNT_ZERO;
            tx_bit_r   <= 3'd0;
            tx_shift_r <= 8'h00;
            tx_r       <= 1'b1;
        end else begin
            case (tx_state_r)
                ST_IDLE: begin
                    tx_cnt_r <= CNT_ZERO;
                    tx_bit_r <= 3'd0;
                    if (pending_r) begin
                        tx_shift_r <= hold_r;
                        tx_r       <= 1'b0;
                        tx_state_r <= ST_START;
                    end else begin
                        tx_r <= 1'b1;
                    end
                end
                ST_START: begin
                    if (tx_cnt_r == BIT_LAST) begin
                        tx_cnt_r   <= CNT_ZERO;
                        tx_r       <= tx_shift_r[0];
                        tx_state_r <= ST_DATA;
                    end else begin
                        tx_cnt_r <= tx_cnt_r + CNT_ONE;
                    end
                end
                ST_DATA: begin
                    if (tx_cnt_r == BIT_LAST) begin
                        tx_cnt_r <= CNT_ZERO;
                        if (tx_bit_r == 3'd7) begin
                            tx_r       <= 1'b1;
                            tx_state_r <= ST_STOP;
                        end else begin
                            tx_bit_r   <= tx_bit_r + 3'd1;
                            tx_shift_r <= {1'b0, tx_shift_r[7:1]};
                            tx_r       <= tx_shift_r[1];
                        end
                    end else begin
                        tx_cnt_r <= tx_cnt_r + CNT_ONE;
                    end
                end
                ST_STOP: begin
                    if (tx_cnt_r == BIT_LAST) begin
                        tx_cnt_r   <= CNT_ZERO;
                        tx_state_r <= ST_IDLE;
                    end else begin
                        tx_cnt_r <= tx_cnt_r + CNT_ONE;
                    end
                end
                default: begin
                    tx_state_r <= ST_IDLE;
                    tx_r       <= 1'b1;
                end
            endcase
        end
    end

    assign tx_data = tx_r;

endmodule

// File: tb/tb_top_uart.sv
// Bench for top_uart: a timeline model of the expected echo frames is compared with tx_data every
// cycle, plus literal bit patterns pinned at mid-bit points of selected frames.
module tb_top_uart;
    localparam int CPB = 434;
    // Edges from the first edge that captures a start bit to tx_data falling:
    // 2 synchronizer flops, mid start bit, 8 data bits + stop, 1 clock to launch.
    localparam int LAT = 2 + CPB / 2 + 9 * CPB + 1;

    logic sys_clk = 1'b0;
    logic sys_rst;
    logic rx_data;
    logic tx_data;

    int   cyc    = 0;
    int   checks = 0;
    int   errors = 0;
    int   last_s = -100000;
    int   fr_start[$];
    logic [7:0] fr_byte[$];
    int   pin_cyc[$];
    logic pin_val[$];

    top_uart dut (
        .sys_clk (sys_clk),
        .sys_rst (sys_rst),
        .rx_data (rx_data),
        .tx_data (tx_data)
    );

    always #10 sys_clk = ~sys_clk;

    // Expected line level after edge c: inside a scheduled frame it follows the frame bits, else idle high.
    function automatic logic exp_tx(input int c);
        int k;
        exp_tx = 1'b1;
        foreach (fr_start[i]) begin
            if (c >= fr_start[i] && c < fr_start[i] + 10 * CPB) begin
                k = (c - fr_start[i]) / CPB;
                if (k == 0)      exp_tx = 1'b0;
                else if (k == 9) exp_tx = 1'b1;
                else             exp_tx = fr_byte[i][k-1];
            end
        end
    endfunction

    // Per-cycle compare against the model, plus pinned literal points.
    always @(posedge sys_clk) begin
        cyc++;
        #1;
        checks++;
        if (tx_data !== exp_tx(cyc)) begin
            errors++;
            if (errors < 20) $display("FAIL tx_line cyc=%0d got=%b want=%b", cyc, tx_data, exp_tx(cyc));
        end
        while (pin_cyc.size() > 0 && pin_cyc[0] <= cyc) begin
            checks++;
            if (pin_cyc[0] < cyc) begin
                errors++;
                $display("FAIL pin_missed cyc=%0d now=%0d", pin_cyc[0], cyc);
            end else if (tx_data !== pin_val[0]) begin
                errors++;
                $display("FAIL tx_pin cyc=%0d got=%b want=%b", cyc, tx_data, pin_val[0]);
            end
            void'(pin_cyc.pop_front());
            void'(pin_val.pop_front());
        end
    end

    // Drive one frame; a good frame is scheduled for echo, optionally with literal pins.
    task automatic send_frame(input logic [7:0] b, input logic stop_bit, input logic pin_it,
                              input logic [9:0] pat, output int s);
        logic [9:0] line;
        int p0;
        line = {stop_bit, b, 1'b0};
        p0   = cyc + 1;
        s    = -1;
        if (stop_bit) begin
            s = (p0 + LAT > last_s + 10 * CPB + 1) ? p0 + LAT : last_s + 10 * CPB + 1;
            fr_start.push_back(s);
            fr_byte.push_back(b);
            last_s = s;
            if (pin_it) begin
                pin_cyc.push_back(s - 1);
                pin_val.push_back(1'b1);
                pin_cyc.push_back(s);
                pin_val.push_back(1'b0);
                for (int k = 0; k < 10; k++) begin
                    pin_cyc.push_back(s + k * CPB + CPB / 2);
                    pin_val.push_back(pat[k]);
                end
            end
        end
        for (int k = 0; k < 10; k++) begin
            rx_data = line[k];
            repeat (CPB) @(negedge sys_clk);
        end
    endtask

    initial begin
        #3000000;
        $display("FAIL watchdog time limit reached at cyc=%0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int s;
        int s34;
        sys_rst = 1'b1;
        rx_data = 1'b1;
        repeat (5) @(negedge sys_clk);
        sys_rst = 1'b0;
        repeat (10 * CPB) @(negedge sys_clk);

        send_frame(8'hAA, 1'b1, 1'b1, 10'b1101010100, s);
        repeat (20 * CPB) @(negedge sys_clk);
        send_frame(8'h55, 1'b1, 1'b1, 10'b1010101010, s);
        repeat (CPB) @(negedge sys_clk);

        rx_data = 1'b0;
        repeat (100) @(negedge sys_clk);
        rx_data = 1'b1;
        repeat (500) @(negedge sys_clk);

        send_frame(8'h3C, 1'b0, 1'b0, 10'b0000000000, s);
        rx_data = 1'b1;
        repeat (500) @(negedge sys_clk);
        send_frame(8'h81, 1'b1, 1'b1, 10'b1100000010, s);

        for (int i = 0; i < 4; i++) begin
            send_frame(8'($urandom_range(0, 255)), 1'b1, 1'b0, 10'b0000000000, s);
            rx_data = 1'b1;
            repeat ($urandom_range(0, 600)) @(negedge sys_clk);
        end

        send_frame(8'h12, 1'b1, 1'b0, 10'b0000000000, s);
        send_frame(8'h34, 1'b1, 1'b0, 10'b0000000000, s34);
        rx_data = 1'b1;

        while (cyc < s34 + CPB + 100) @(negedge sys_clk);
        checks++;
        if (tx_data !== 1'b0) begin
            errors++;
            $display("FAIL tx_mid_frame cyc=%0d got=%b want=0", cyc, tx_data);
        end
        sys_rst = 1'b1;
        pin_cyc.push_back(cyc + 1);
        pin_val.push_back(1'b1);
        fr_start.delete();
        fr_byte.delete();
        last_s = -100000;
        repeat (3) @(negedge sys_clk);
        sys_rst = 1'b0;
        repeat (10 * CPB + 700) @(negedge sys_clk);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end
endmodule
